e_x_postprocess_stream: RTL

Streaming, parametrised successor to the single-sample exponential post-processor in the random-normal generator chain. It takes candidate samples (arg, orig_num, test_num) from the e^x evaluation stage and performs the rejection test. Accepted samples get an optional random sign and are buffered in a small output FIFO. Valid/ready handshakes on both sides, plus saturating accept/reject statistics counters.

---
 rtl/e_x_pp_pkg.sv | 12 +
 rtl/e_x_pp_if.sv | 13 +
 rtl/e_x_pp_fifo.sv | 36 +++
 rtl/e_x_postprocess_stream.sv | 70 +++++++
 4 files changed

// File: rtl/e_x_pp_pkg.sv
// e_x_pp_pkg: shared constants and candidate record for the e^x post-processing stream
package e_x_pp_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int LVL_W     = $clog2(DEF_DEPTH) + 1;
    localparam int SIGN_BIT  = 0;
    typedef struct packed {
        logic [DEF_WIDTH-1:0] arg;
        logic [DEF_WIDTH-1:0] orig_num;
        logic [DEF_WIDTH-1:0] test_num;
    } cand_t;
endpackage

// File: rtl/e_x_pp_if.sv
// e_x_pp_if: candidate input and sample output handshakes of the post-processor
interface e_x_pp_if #(parameter int WIDTH = 32);
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] arg, orig_num, test_num, number;
    modport master (
        output in_valid, arg, orig_num, test_num, out_ready,
        input  in_ready, out_valid, number
    );
    modport slave (
        input  in_valid, arg, orig_num, test_num, out_ready,
        output in_ready, out_valid, number
    );
endinterface

// File: rtl/e_x_pp_fifo.sv
// e_x_pp_fifo: first-word-fall-through sync FIFO with level output
module e_x_pp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop;
    assign valid = level != '0;
    assign pop   = valid && rd_en;
    // Empty FIFO presents zero so the output is defined straight out of reset
    assign dout  = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(wr_en) - LW'(pop);
        end
endmodule

// File: rtl/e_x_postprocess_stream.sv
// e_x_postprocess_stream: e^x rejection test with optional random sign, output FIFO and stats
module e_x_postprocess_stream
    import e_x_pp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16,
    parameter bit SIGN_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    e_x_pp_if.slave                       s,
    input  logic                          clr_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          accept_cnt,
    output logic [CNT_WIDTH-1:0]          reject_cnt
);
    logic             s1_v, s2_v, s2_acc, sign, acc, in_fire;
    logic [WIDTH-1:0] s1_arg, s1_orig, s1_test, s2_val, val;
    // Slots are reserved for everything in flight, so the FIFO can never overflow
    assign s.in_ready = rst_n && (int'(fifo_level) + int'(s1_v) + int'(s2_v) < FIFO_DEPTH);
    assign in_fire    = s.in_valid && s.in_ready;
    always_comb begin
        sign = SIGN_EN && s1_test[SIGN_BIT];
        acc  = SIGN_EN ? (s1_test[WIDTH-1:1] < s1_orig[WIDTH-1:1]) && !s1_arg[WIDTH-1]
                       : s1_test < s1_orig;
        val  = sign ? -s1_arg : s1_arg;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_arg  <= '0;
            s1_orig <= '0;
            s1_test <= '0;
            s2_v    <= 1'b0;
            s2_acc  <= 1'b0;
            s2_val  <= '0;
        end else begin
            s1_v <= in_fire;
            if (in_fire) begin
                s1_arg  <= s.arg;
                s1_orig <= s.orig_num;
                s1_test <= s.test_num;
            end
            s2_v   <= s1_v;
            s2_acc <= acc;
            s2_val <= val;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (clr_cnt) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (s2_v) begin
            if (s2_acc && !(&accept_cnt)) accept_cnt <= accept_cnt + 1'b1;
            if (!s2_acc && !(&reject_cnt)) reject_cnt <= reject_cnt + 1'b1;
        end
    e_x_pp_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (s2_v && s2_acc),
        .din   (s2_val),
        .rd_en (s.out_ready),
        .dout  (s.number),
        .valid (s.out_valid),
        .level (fifo_level)
    );
endmodule
